// File: rtl/adder_mw_ctrl_if.sv
// Requester-side bundle of the multi-word adder controller:
// start/done handshake, wide operands and wide result.
interface adder_mw_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) ();
  logic                     start;
  logic [WIDTH*WORDS-1:0]   a_in;
  logic [WIDTH*WORDS-1:0]   b_in;
  logic                     ci_in;
  logic                     busy;
  logic                     done;
  logic [WIDTH*WORDS-1:0]   sum_out;
  logic                     co_out;

  modport master (
    output start, a_in, b_in, ci_in,
    input  busy, done, sum_out, co_out
  );

  modport slave (
    input  start, a_in, b_in, ci_in,
    output busy, done, sum_out, co_out
  );
endinterface

// File: rtl/adder_mw_ctrl.sv
// Multi-precision add controller: time-multiplexes one WIDTH-bit adder over
// WORDS chunks, least-significant first, chaining the carry through a register.
module adder_mw_ctrl #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_mw_ctrl_if.slave   req,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_co
);

  localparam int TOTAL = WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [TOTAL-1:0]   a_r;
  logic [TOTAL-1:0]   b_r;
  logic               carry_r;
  logic [TOTAL-1:0]   sum_r;
  logic               co_r;
  logic               busy_r;
  logic               done_r;

  // Chunk mux written as a compare chain so a non-power-of-two WORDS never
  // produces an out-of-range part select.
  function automatic logic [WIDTH-1:0] chunk_of(input logic [TOTAL-1:0] v,
                                                input logic [IDX_W-1:0] i);
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    for (int k = 0; k < WORDS; k++) begin
      r = (i == IDX_W'(k)) ? v[k*WIDTH +: WIDTH] : r;
    end
    return r;
  endfunction

  assign req.busy    = busy_r;
  assign req.done    = done_r;
  assign req.sum_out = sum_r;
  assign req.co_out  = co_r;

  // Adder drive: current chunk and chained carry while running, quiet otherwise.
  always_comb begin
    add_a  = {WIDTH{1'b0}};
    add_b  = {WIDTH{1'b0}};
    add_ci = 1'b0;
    if (state_r == RUN) begin
      add_a  = chunk_of(a_r, idx_r);
      add_b  = chunk_of(b_r, idx_r);
      add_ci = carry_r;
    end else begin
      add_a  = {WIDTH{1'b0}};
      add_b  = {WIDTH{1'b0}};
      add_ci = 1'b0;
    end
  end

  // Sequencer: accept in IDLE, one chunk per RUN cycle, single-cycle DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
      a_r     <= {TOTAL{1'b0}};
      b_r     <= {TOTAL{1'b0}};
      carry_r <= 1'b0;
      sum_r   <= {TOTAL{1'b0}};
      co_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (req.start) begin
            a_r     <= req.a_in;
            b_r     <= req.b_in;
            carry_r <= req.ci_in;
            idx_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx_r == IDX_W'(k)) begin
              sum_r[k*WIDTH +: WIDTH] <= add_sum;
            end
          end
          carry_r <= add_co;
          if (idx_r == LAST_IDX) begin
            co_r    <= add_co;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_mw_ctrl.sv
// Bench for adder_mw_ctrl: 16-bit default instance with vectors and corner
// sequences, plus a 2x3 instance swept with random operands.
module tb_adder_mw_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_mw_ctrl_if #(.WIDTH(4), .WORDS(4)) if0 ();
  adder_mw_ctrl_if #(.WIDTH(2), .WORDS(3)) if1 ();

  logic [3:0] a0, b0, s0;
  logic       ci0, co0;
  logic [1:0] a1, b1, s1;
  logic       ci1, co1;

  // Behavioural ripple adders shared with each controller
  assign {co0, s0} = {1'b0, a0} + {1'b0, b0} + {4'b0000, ci0};
  assign {co1, s1} = {1'b0, a1} + {1'b0, b1} + {2'b00, ci1};

  adder_mw_ctrl #(.WIDTH(4), .WORDS(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(if0.slave),
    .add_a(a0), .add_b(b0), .add_ci(ci0), .add_sum(s0), .add_co(co0)
  );

  adder_mw_ctrl #(.WIDTH(2), .WORDS(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(if1.slave),
    .add_a(a1), .add_b(b1), .add_ci(ci1), .add_sum(s1), .add_co(co1)
  );

  int checks = 0;
  int errors = 0;
  int done0_cnt = 0;
  int sweep_cnt = 0;
  logic [16:0] q0[$];
  logic [6:0]  q1[$];
  logic [16:0] e0;
  logic [6:0]  e1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [16:0] exp;
  } vec_t;
  vec_t vt[7];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Scoreboard for the 16-bit instance
  always @(negedge clk) begin
    if (if0.done === 1'b1) begin
      done0_cnt++;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d0_unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        e0 = q0.pop_front();
        chk("d0_result", {15'd0, if0.co_out, if0.sum_out}, {15'd0, e0});
      end
    end
  end

  // Scoreboard for the 6-bit instance
  always @(negedge clk) begin
    if (if1.done === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d1_unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        e1 = q1.pop_front();
        sweep_cnt++;
        chk("d1_result", {25'd0, if1.co_out, if1.sum_out}, {25'd0, e1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while (if0.busy && n < 50) begin
      tick();
      n++;
    end
    if (if0.busy) chk("d0_idle_timeout", {31'd0, if0.busy}, 32'd0);
  endtask

  task automatic op0(input logic [15:0] a, input logic [15:0] b, input logic ci,
                     input logic [16:0] exp);
    int n;
    wait_idle0();
    if0.a_in = a; if0.b_in = b; if0.ci_in = ci; if0.start = 1'b1;
    q0.push_back(exp);
    tick();
    if0.start = 1'b0;
    chk("d0_busy_after_start", {31'd0, if0.busy}, 32'd1);
    n = 0;
    while (if0.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("d0_latency", n, 32'd4);
    tick();
    chk("d0_done_one_cycle", {31'd0, if0.done}, 32'd0);
    chk("d0_idle_after_done", {31'd0, if0.busy}, 32'd0);
    chk("d0_result_hold", {15'd0, if0.co_out, if0.sum_out}, {15'd0, exp});
  endtask

  task automatic op1(input logic [5:0] a, input logic [5:0] b, input logic ci);
    int n;
    n = 0;
    while (if1.busy && n < 50) begin
      tick();
      n++;
    end
    if1.a_in = a; if1.b_in = b; if1.ci_in = ci; if1.start = 1'b1;
    q1.push_back({1'b0, a} + {1'b0, b} + {6'd0, ci});
    tick();
    if1.start = 1'b0;
    n = 0;
    while (if1.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("d1_latency", n, 32'd3);
    tick();
  endtask

  logic [15:0] ba[4];
  logic [15:0] bb[4];
  logic        bc[4];
  logic [16:0] be[4];
  int          acc_cyc[4];

  initial begin
    int acc, cyc, dc;
    logic prev;
    logic [15:0] ca;

    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
    vt[1] = '{16'h0000, 16'h0000, 1'b1, 17'h00001};
    vt[2] = '{16'h1234, 16'h4321, 1'b0, 17'h05555};
    vt[3] = '{16'h8000, 16'h8000, 1'b1, 17'h10001};
    vt[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    vt[5] = '{16'h00FF, 16'h0F01, 1'b0, 17'h01000};
    vt[6] = '{16'hA5A5, 16'h5A5A, 1'b0, 17'h0FFFF};

    ba[0] = 16'h0001; bb[0] = 16'h0002; bc[0] = 1'b0; be[0] = 17'h00003;
    ba[1] = 16'h7FFF; bb[1] = 16'h0001; bc[1] = 1'b1; be[1] = 17'h08001;
    ba[2] = 16'hFFFF; bb[2] = 16'hFFFF; bc[2] = 1'b0; be[2] = 17'h1FFFE;
    ba[3] = 16'h1111; bb[3] = 16'h2222; bc[3] = 1'b1; be[3] = 17'h03334;

    if0.start = 1'b0; if0.a_in = 16'h0000; if0.b_in = 16'h0000; if0.ci_in = 1'b0;
    if1.start = 1'b0; if1.a_in = 6'd0; if1.b_in = 6'd0; if1.ci_in = 1'b0;

    tick();
    tick();
    chk("rst_busy", {31'd0, if0.busy}, 32'd0);
    chk("rst_done", {31'd0, if0.done}, 32'd0);
    chk("rst_sum", {15'd0, if0.co_out, if0.sum_out}, 32'd0);
    chk("rst_add", {23'd0, a0, b0, ci0}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Vector table
    for (int i = 0; i < 7; i++) op0(vt[i].a, vt[i].b, vt[i].ci, vt[i].exp);

    // Carry-in only reaches the adder in the first RUN cycle
    wait_idle0();
    if0.a_in = 16'h0000; if0.b_in = 16'h0000; if0.ci_in = 1'b1; if0.start = 1'b0;
    tick();
    chk("d0_add_ci_idle", {31'd0, ci0}, 32'd0);
    if0.start = 1'b1;
    q0.push_back(17'h00001);
    tick();
    if0.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("d0_add_ci_run", {31'd0, ci0}, (c == 0) ? 32'd1 : 32'd0);
      tick();
    end
    chk("d0_done_ci_op", {31'd0, if0.done}, 32'd1);
    tick();

    // Start during RUN is ignored; chunks walk LS first
    wait_idle0();
    dc = done0_cnt;
    ca = 16'h1234;
    if0.a_in = ca; if0.b_in = 16'h4321; if0.ci_in = 1'b0; if0.start = 1'b1;
    q0.push_back(17'h05555);
    tick();
    if0.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("d0_add_a_chunk", {28'd0, a0}, {28'd0, ca[c*4 +: 4]});
      if (c == 1) begin
        if0.a_in = 16'hFFFF; if0.b_in = 16'hFFFF; if0.ci_in = 1'b1; if0.start = 1'b1;
      end else begin
        if0.start = 1'b0;
      end
      tick();
    end
    chk("d0_done_ignore_op", {31'd0, if0.done}, 32'd1);
    for (int c = 0; c < 4; c++) tick();
    chk("d0_ignored_no_restart", {31'd0, if0.busy}, 32'd0);
    chk("d0_single_done", done0_cnt - dc, 32'd1);

    // Asynchronous reset mid-RUN
    if0.a_in = 16'h1111; if0.b_in = 16'h1111; if0.ci_in = 1'b1; if0.start = 1'b1;
    q0.push_back(17'h02223);
    tick();
    if0.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, if0.busy}, 32'd0);
    chk("arst_done", {31'd0, if0.done}, 32'd0);
    chk("arst_sum", {15'd0, if0.co_out, if0.sum_out}, 32'd0);
    chk("arst_add", {23'd0, a0, b0, ci0}, 32'd0);
    q0.delete();
    dc = done0_cnt;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("arst_no_done", done0_cnt - dc, 32'd0);
    op0(vt[3].a, vt[3].b, vt[3].ci, vt[3].exp);

    // Back-to-back with start held high
    wait_idle0();
    dc = done0_cnt;
    prev = if0.busy;
    if0.a_in = ba[0]; if0.b_in = bb[0]; if0.ci_in = bc[0]; if0.start = 1'b1;
    q0.push_back(be[0]);
    acc = 0;
    cyc = 0;
    while (acc < 4 && cyc < 80) begin
      tick();
      cyc++;
      if (if0.busy && !prev) begin
        acc_cyc[acc] = cyc;
        acc++;
        if (acc < 4) begin
          if0.a_in = ba[acc]; if0.b_in = bb[acc]; if0.ci_in = bc[acc];
          q0.push_back(be[acc]);
        end else begin
          if0.start = 1'b0;
        end
      end
      prev = if0.busy;
    end
    if0.start = 1'b0;
    chk("d0_b2b_accepts", acc, 32'd4);
    for (int i = 1; i < acc; i++) chk("d0_b2b_period", acc_cyc[i] - acc_cyc[i-1], 32'd6);
    wait_idle0();
    tick();
    chk("d0_b2b_dones", done0_cnt - dc, acc);

    // 2-bit x 3-word sweep: corners then random
    op1(6'd63, 6'd63, 1'b1);
    op1(6'd0, 6'd0, 1'b0);
    op1(6'd63, 6'd1, 1'b0);
    op1(6'd42, 6'd21, 1'b1);
    for (int i = 0; i < 500; i++) begin
      op1(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end
    tick();

    chk("sweep_ran", {31'd0, (sweep_cnt >= 504)}, 32'd1);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
